// File: rtl/pe_col_dispatch.sv
// pe_col_dispatch: slices a row guard map into 6-bit segments for the PE column controller.
// Optional PE_DISPATCH_SKIP_EMPTY_EN: skip zero segments (never the last, never in 4-bit mode).
module pe_col_dispatch #(
  parameter int NUM_SEG = 4,
  parameter int GUARD_W = 6 * NUM_SEG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               row_valid,
  output logic               row_ready,
  input  logic [GUARD_W-1:0] row_guard,
  input  logic               row_bit_mode,
  input  logic               row_kernel_mode,
  input  logic               row_frame_start,
  output logic               ctrl_valid,
  input  logic               ctrl_ready,
  input  logic               ctrl_finish,
  output logic [5:0]         guard_map_o,
  output logic               bit_mode_o,
  output logic               kernel_mode_o,
  output logic               is_odd_row_o,
  output logic               end_of_row_o,
  output logic               row_done,
  output logic               busy
);

  localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [SEG_W-1:0] LAST = SEG_W'(NUM_SEG - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_FIN
  } state_t;

  state_t             state;
  logic [GUARD_W-1:0] guard_q;
  logic [SEG_W-1:0]   seg_idx;
  logic               last_pending;
  logic               bit_mode_q;
  logic               kernel_mode_q;
  logic               parity;
  logic [5:0]         cur_seg;
  logic               is_last;
  logic               skip;
  logic               accept;

  // Current segment of the latched guard map
  always_comb begin
    cur_seg = guard_q[6*seg_idx +: 6];
  end

  assign is_last = (seg_idx == LAST);

`ifdef PE_DISPATCH_SKIP_EMPTY_EN
  assign skip = (state == ISSUE) && !bit_mode_q
              && !is_last && (cur_seg == 6'd0);
`else
  assign skip = 1'b0;
`endif

  assign ctrl_valid    = (state == ISSUE) && !skip;
  assign accept        = ctrl_valid && ctrl_ready;
  assign row_ready     = (state == IDLE) && !rst;
  assign busy          = (state != IDLE);
  assign guard_map_o   = (state == ISSUE) ? cur_seg : 6'd0;
  assign end_of_row_o  = (state == ISSUE) && is_last;
  assign bit_mode_o    = bit_mode_q;
  assign kernel_mode_o = kernel_mode_q;
  assign is_odd_row_o  = parity;

  // Done fires on the finish of the last segment, including same-cycle finish
  assign row_done = !rst && (
      (state == WAIT_FIN && ctrl_finish && last_pending)
    || (accept && is_last && ctrl_finish));

  // Row FSM: accept, issue segments, wait for each finish
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      guard_q       <= '0;
      seg_idx       <= '0;
      last_pending  <= 1'b0;
      bit_mode_q    <= 1'b0;
      kernel_mode_q <= 1'b0;
      parity        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (row_valid) begin
            guard_q       <= row_guard;
            bit_mode_q    <= row_bit_mode;
            kernel_mode_q <= row_kernel_mode;
            parity        <= row_frame_start ? 1'b1 : ~parity;
            seg_idx       <= '0;
            last_pending  <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (skip) begin
            seg_idx <= seg_idx + 1'b1;
          end else if (ctrl_ready) begin
            if (is_last) begin
              if (ctrl_finish) begin
                state <= IDLE;
              end else begin
                last_pending <= 1'b1;
                state        <= WAIT_FIN;
              end
            end else begin
              seg_idx <= seg_idx + 1'b1;
              state   <= ctrl_finish ? ISSUE : WAIT_FIN;
            end
          end
        end
        WAIT_FIN: begin
          if (ctrl_finish) begin
            state <= last_pending ? IDLE : ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_col_dispatch.sv
// tb_pe_col_dispatch: randomized self-checking bench for pe_col_dispatch.
// Reference: per-row list of segments expected on the controller interface.
module tb_pe_col_dispatch;

  localparam int N = 4;

`ifdef PE_DISPATCH_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        row_valid;
  logic        row_ready;
  logic [23:0] row_guard;
  logic        row_bit_mode;
  logic        row_kernel_mode;
  logic        row_frame_start;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic        ctrl_finish;
  logic [5:0]  guard_map_o;
  logic        bit_mode_o;
  logic        kernel_mode_o;
  logic        is_odd_row_o;
  logic        end_of_row_o;
  logic        row_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit par_m  = 1'b0;
  int n_acc;

  pe_col_dispatch #(.NUM_SEG(N)) dut (
    .clk(clk), .rst(rst),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_guard(row_guard), .row_bit_mode(row_bit_mode),
    .row_kernel_mode(row_kernel_mode),
    .row_frame_start(row_frame_start),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .ctrl_finish(ctrl_finish), .guard_map_o(guard_map_o),
    .bit_mode_o(bit_mode_o), .kernel_mode_o(kernel_mode_o),
    .is_odd_row_o(is_odd_row_o), .end_of_row_o(end_of_row_o),
    .row_done(row_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Runs one row; entered and left at a negedge.
  // fin_mode: 0 finish next cycle, 1 same cycle, 2 random.
  task automatic run_row(input logic [23:0] g, input bit bm,
                         input bit km, input bit fs,
                         input int fin_mode, input int hold_n);
    logic [5:0] eg[$];
    int         ei[$];
    logic [5:0] s, x, sg;
    logic       se;
    int         last_i, hold, fin_cnt, cyc;
    bit         waiting, stall, done, want_v, exp_par;
    for (int k = 0; k < N; k++) begin
      s = g[6*k +: 6];
      if (k == N-1 || !SKIP || bm || s != 6'd0) begin
        eg.push_back(s);
        ei.push_back(k);
      end
    end
    exp_par = fs ? 1'b1 : !par_m;
    par_m   = exp_par;
    hold = hold_n; waiting = 0; stall = 0; done = 0;
    want_v = 0; last_i = 0; fin_cnt = 0; n_acc = 0;
    sg = '0; se = 1'b0;
    row_valid = 1; row_guard = g; row_bit_mode = bm;
    row_kernel_mode = km; row_frame_start = fs;
    #1;
    checks++;
    if (row_ready !== 1'b1) begin
      errors++;
      $display("FAIL row_ready_idle: got %b want 1", row_ready);
    end
    @(negedge clk);
    row_valid = 0; row_guard = 24'($urandom);
    row_bit_mode = !bm; row_kernel_mode = !km;
    row_frame_start = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || row_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_state: busy %b ready %b want 1 0",
               busy, row_ready);
    end
    checks++;
    if (is_odd_row_o !== exp_par || bit_mode_o !== bm
        || kernel_mode_o !== km) begin
      errors++;
      $display("FAIL row_flags: odd %b bm %b km %b want %b %b %b",
               is_odd_row_o, bit_mode_o, kernel_mode_o,
               exp_par, bm, km);
    end
    checks++;
    if (ctrl_valid !== 1'(ei[0] == 0)) begin
      errors++;
      $display("FAIL first_valid: got %b want %b",
               ctrl_valid, ei[0] == 0);
    end
    cyc = 0;
    while (!done && cyc < 200) begin
      cyc++;
      ctrl_ready = 0;
      ctrl_finish = 0;
      if (stall) begin
        checks++;
        if (ctrl_valid !== 1'b1 || guard_map_o !== sg
            || end_of_row_o !== se) begin
          errors++;
          $display("FAIL stall_stable: v %b g %h e %b want 1 %h %b",
                   ctrl_valid, guard_map_o, end_of_row_o, sg, se);
        end
      end
      stall = 0;
      if (want_v) begin
        checks++;
        if (ctrl_valid !== 1'b1) begin
          errors++;
          $display("FAIL bypass_next: valid %b want 1", ctrl_valid);
        end
        want_v = 0;
      end
      if (waiting) begin
        checks++;
        if (ctrl_valid !== 1'b0) begin
          errors++;
          $display("FAIL wait_valid: got %b want 0", ctrl_valid);
        end
        if (fin_cnt == 0) begin
          ctrl_finish = 1;
          waiting = 0;
        end else begin
          fin_cnt--;
        end
      end else if (ctrl_valid === 1'b1) begin
        if (hold > 0 || (fin_mode == 2 && $urandom_range(0, 3) == 0)) begin
          if (hold > 0) hold--;
          stall = 1;
          sg = guard_map_o;
          se = end_of_row_o;
        end else begin
          ctrl_ready = 1;
          n_acc++;
          checks++;
          if (eg.size() == 0) begin
            errors++;
            $display("FAIL extra_issue: got %h want none", guard_map_o);
          end else begin
            last_i = ei.pop_front();
            x = eg.pop_front();
            if (guard_map_o !== x || end_of_row_o !== 1'(eg.size() == 0)) begin
              errors++;
              $display("FAIL issue_seg%0d: g %h e %b want %h %b", last_i,
                       guard_map_o, end_of_row_o, x, eg.size() == 0);
            end
          end
          if (fin_mode == 1 || (fin_mode == 2 && $urandom_range(0, 1) == 1)) begin
            ctrl_finish = 1;
            if (ei.size() > 0 && ei[0] == last_i + 1) want_v = 1;
          end else begin
            waiting = 1;
            fin_cnt = (fin_mode == 0) ? 0 : $urandom_range(0, 3);
          end
        end
      end
      #1;
      checks++;
      if (row_done !== 1'(ctrl_finish && eg.size() == 0)) begin
        errors++;
        $display("FAIL row_done: got %b want %b",
                 row_done, ctrl_finish && eg.size() == 0);
      end
      if (row_done === 1'b1) done = 1;
      @(negedge clk);
    end
    ctrl_ready = 0;
    ctrl_finish = 0;
    checks++;
    if (!done || eg.size() != 0) begin
      errors++;
      $display("FAIL row_end: done %b left %0d want 1 0", done, eg.size());
    end
    #1;
    checks++;
    if (busy !== 1'b0 || row_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_done: busy %b ready %b want 0 1",
               busy, row_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1; row_valid = 0; row_guard = '0; row_bit_mode = 0;
    row_kernel_mode = 0; row_frame_start = 0;
    ctrl_ready = 0; ctrl_finish = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (row_ready !== 1'b0 || ctrl_valid !== 1'b0 || busy !== 1'b0
        || row_done !== 1'b0 || guard_map_o !== 6'd0
        || end_of_row_o !== 1'b0 || bit_mode_o !== 1'b0
        || kernel_mode_o !== 1'b0 || is_odd_row_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: rdy %b v %b busy %b g %h odd %b",
               row_ready, ctrl_valid, busy, guard_map_o, is_odd_row_o);
    end
    rst = 0;
    #1;
    checks++;
    if (row_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: row_ready %b want 1", row_ready);
    end
    par_m = 0;
    @(negedge clk);
  endtask

  task automatic test_first_row();
    run_row(24'h00003F, 0, 0, 0, 0, 0);
    checks++;
    if (n_acc != (SKIP ? 2 : 4)) begin
      errors++;
      $display("FAIL first_row_count: got %0d want %0d",
               n_acc, SKIP ? 2 : 4);
    end
  endtask

  task automatic test_parity();
    run_row(24'hABCDEF, 0, 1, 1, 0, 0);
    run_row(24'h123456, 1, 0, 0, 0, 0);
    checks++;
    if (is_odd_row_o !== 1'b0) begin
      errors++;
      $display("FAIL parity_second: got %b want 0", is_odd_row_o);
    end
    run_row(24'hFEDCBA, 0, 0, 1, 0, 0);
    checks++;
    if (is_odd_row_o !== 1'b1) begin
      errors++;
      $display("FAIL parity_third: got %b want 1", is_odd_row_o);
    end
  endtask

  task automatic test_backpressure();
    run_row(24'h5A5A5A, 0, 1, 0, 0, 5);
  endtask

  task automatic test_same_cycle_finish();
    run_row(24'h000000, 1, 0, 0, 1, 0);
    checks++;
    if (n_acc != 4) begin
      errors++;
      $display("FAIL bypass_count: got %0d want 4", n_acc);
    end
    run_row(24'h00FF00, 0, 0, 0, 1, 0);
  endtask

  task automatic test_skip_empty();
    run_row(24'h000000, 0, 0, 0, 0, 0);
    checks++;
    if (n_acc != (SKIP ? 1 : 4)) begin
      errors++;
      $display("FAIL skip_dense0: got %0d want %0d", n_acc, SKIP ? 1 : 4);
    end
    run_row(24'h000000, 1, 0, 0, 0, 0);
    checks++;
    if (n_acc != 4) begin
      errors++;
      $display("FAIL skip_bitmode: got %0d want 4", n_acc);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++)
      run_row(24'($urandom), 1'($urandom), 1'($urandom), 0, 1, 0);
  endtask

  task automatic test_random();
    logic [23:0] g;
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < N; k++)
        g[6*k +: 6] = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
      run_row(g, 1'($urandom), 1'($urandom),
              $urandom_range(0, 3) == 0, 2, $urandom_range(0, 2));
    end
  endtask

  task automatic test_rst_midrow();
    row_valid = 1; row_guard = 24'h123456; row_bit_mode = 1;
    row_kernel_mode = 1; row_frame_start = 0;
    @(negedge clk);
    row_valid = 0;
    ctrl_ready = 1;
    @(negedge clk);
    ctrl_ready = 0;
    checks++;
    if (busy !== 1'b1 || ctrl_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrow_wait: busy %b v %b want 1 0", busy, ctrl_valid);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ctrl_valid !== 1'b0 || row_ready !== 1'b0
        || is_odd_row_o !== 1'b0 || bit_mode_o !== 1'b0
        || guard_map_o !== 6'd0) begin
      errors++;
      $display("FAIL midrow_rst: busy %b v %b rdy %b odd %b bm %b",
               busy, ctrl_valid, row_ready, is_odd_row_o, bit_mode_o);
    end
    rst = 0;
    par_m = 0;
    #1;
    checks++;
    if (row_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrow_release: row_ready %b want 1", row_ready);
    end
    @(negedge clk);
    run_row(24'h0F0F0F, 0, 0, 0, 2, 0);
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_parity();
    test_backpressure();
    test_same_cycle_finish();
    test_skip_empty();
    test_back_to_back();
    test_random();
    test_rst_midrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
